// File: rtl/ps2_host_tx_pkg.sv
// Shared keyboard-subsystem definitions for the PS/2 host transmit path:
// transmitter state encoding, frame length, command bytes and frame builder.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // Bits shifted out after device edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus falling-edge
// detection on the synchronized clock.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    input  logic reload,
    output logic clk_sync,
    output logic data_sync,
    output logic fall
);

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    always_comb begin
        clk_meta_d  = clk_in;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = data_in;
        data_sync_d = data_meta_q;
        // The host is releasing a clock it held low itself; preset the chain
        // high so that self-inflicted low never shows up as a device edge.
        if (reload) begin
            clk_meta_d = 1'b1;
            clk_sync_d = 1'b1;
            clk_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign clk_sync  = clk_sync_q;
    assign data_sync = data_sync_q;
    assign fall      = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 11-bit frame, ACK).
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [3:0] LAST_DATA_BIT = 4'(PS2_FRAME_BITS - 2);

    ps2_tx_state_t    state_q, state_d;
    logic [9:0]       frame_q, frame_d;
    logic [3:0]       bit_q, bit_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic             err_flag_q, err_flag_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    logic clk_sync, data_sync, fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .clk_in    (ps2_clk_in),
        .data_in   (ps2_data_in),
        .reload    (state_q == REQ),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .fall      (fall)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_d      = bit_q;
        inh_d      = inh_q;
        err_flag_d = err_flag_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                bit_d     = 4'd0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    frame_d    = ps2_tx_frame(tx_data);
                    inh_d      = '0;
                    err_flag_d = 1'b0;
                    clk_oe_d   = 1'b1;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            REQ: begin
                clk_oe_d = 1'b0;
                state_d  = SEND;
            end
            SEND: begin
                if (fall) begin
                    data_oe_d = ~frame_q[bit_q];
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == LAST_DATA_BIT) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    err_flag_d = data_sync;
                    bit_d      = bit_q + 4'd1;
                    state_d    = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // The done pulse is issued from here so tx_ready stays low during it.
                if (done_q) begin
                    state_d = IDLE;
                end else if (clk_sync && data_sync) begin
                    done_d = 1'b1;
                    err_d  = err_flag_q;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        wd_d = '0;
        if ((state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) && !done_q && !fall) begin
            if (wd_q == WD_LAST) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b1;
                err_d     = 1'b1;
                state_d   = WAIT_IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            bit_q      <= 4'd0;
            inh_q      <= '0;
            err_flag_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_q      <= bit_d;
            inh_q      <= inh_d;
            err_flag_q <= err_flag_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_q       <= wd_d;
`endif
        end
    end

    assign tx_ready    = ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain PS/2 device model, expected-frame queue
// filled at send time and drained by a monitor on every tx_done pulse.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 500;
    localparam int W   = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, tx_done, tx_err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin, ps2_data_pin;

    // Open-drain lines: either side may pull low.
    assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_pin = dev_data & ~ps2_data_oe;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int n_pushed = 0;
    logic [9:0]   obs_frame = '0;
    logic [W-1:0] exp_q[$];

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Expected entry: {check_frame, err, stop, parity, data[7:0]}.
    function automatic logic [W-1:0] model(input logic [7:0] b, input bit ack, input bit full);
        int ones;
        logic parity;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        parity = ((ones % 2) == 0);
        return {full, !(ack && full), 1'b1, parity, b};
    endfunction

    // Monitor: pops one expectation per tx_done pulse.
    initial begin : monitor
        logic [W-1:0] e;
        bit prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_done = 1'b0;
            end else begin
                check("err_only_with_done", int'(tx_err && !tx_done), 0);
                if (prev_done) begin
                    check("done_one_cycle", tx_done, 0);
                    check("ready_after_done", tx_ready, 1);
                end
                if (tx_done) begin
                    done_cnt++;
                    check("ready_low_in_done", tx_ready, 0);
                    check("clk_oe_at_done", ps2_clk_oe, 0);
                    check("data_oe_at_done", ps2_data_oe, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_err", tx_err, int'(e[10]));
                        if (e[11]) check("frame_bits", int'(obs_frame), int'(e[9:0]));
                    end
                end
                prev_done = tx_done;
            end
        end
    end

    // stop_after: device goes silent after that edge (0 = complete frame).
    // abort_after: reset is asserted during the low phase of that edge (0 = none).
    task automatic send_frame(input logic [7:0] b, input bit ack, input int stop_after,
                              input int abort_after, input bit spurious);
        int n, lo, hi, limit, start_done;
        @(negedge clk);
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", tx_ready, 1);
        if (abort_after == 0) begin
            exp_q.push_back(model(b, ack, stop_after == 0));
            n_pushed++;
        end
        start_done = done_cnt;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 4 * INH) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("req_clk_oe", ps2_clk_oe, 1);
        check("req_data_oe", ps2_data_oe, 1);
        @(negedge clk);
        check("send_clk_oe", ps2_clk_oe, 0);
        check("start_data_oe", ps2_data_oe, 1);
        if (spurious) begin
            tx_valid = 1'b1;
            tx_data  = ~b;
        end
        repeat ($urandom_range(2, 10)) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            lo = $urandom_range(6, 12);
            hi = $urandom_range(4, 10);
            if (e == 11) begin
                tx_valid = 1'b0;
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (3) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (lo) @(negedge clk);
            if (e <= 10) obs_frame[e-1] = ps2_data_pin;
            if (e == abort_after) begin
                check("abort_pre_data_oe", ps2_data_oe, 1);
                rst = 1'b1;
                #1;
                check("abort_clk_oe", ps2_clk_oe, 0);
                check("abort_data_oe", ps2_data_oe, 0);
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                tx_valid = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                check("abort_ready", tx_ready, 1);
                check("abort_busy", busy, 0);
                check("abort_no_done", tx_done, 0);
                return;
            end
            dev_clk  = 1'b1;
            dev_data = 1'b1;
            repeat (hi) @(negedge clk);
            if (e == stop_after) break;
        end
        tx_valid = 1'b0;
        limit = (stop_after != 0) ? TMO + 300 : 300;
        n = 0;
        while (done_cnt == start_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_count_per_frame", done_cnt - start_done, 1);
    endtask

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_clk_oe", ps2_clk_oe, 0);
        check("idle_data_oe", ps2_data_oe, 0);
        check("idle_done", tx_done, 0);
        check("idle_err", tx_err, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", tx_ready, 1);

        send_frame(8'hED, 1'b1, 0, 0, 1'b0);
        send_frame(8'h01, 1'b1, 0, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 0, 1'b0);
        send_frame(8'hF4, 1'b0, 0, 0, 1'b0);
        send_frame(8'hED, 1'b1, 0, 0, 1'b1);
        send_frame(8'h0F, 1'b1, 0, 5, 1'b0);
        send_frame(8'hF4, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom), $urandom_range(0, 3) != 0, 0, 0, 1'($urandom_range(0, 1)));
        end
`ifdef PS2_TX_TIMEOUT_EN
        send_frame(8'h5A, 1'b1, 4, 0, 1'b0);
        send_frame(8'hF4, 1'b1, 0, 0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("total_done", done_cnt, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
